// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm : shared debug-module package.
//
// Purpose
//   Types and encodings shared by the DMI datapath: the request/response
//   structs carried across the JTAG<->core crossing, the DMI op codes and
//   the DMI response codes.
//
// Contents
//   dmi_req_t   {addr[6:0], op[1:0], data[31:0]}
//   dmi_resp_t  {data[31:0], resp[1:0]}
//   DTM_NOP / DTM_READ / DTM_WRITE     op encodings (3 is reserved)
//   DTM_SUCCESS / DTM_FAILED           resp encodings
// ---------------------------------------------------------------------------
package dm;

    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    // op is carried as a raw 2-bit field so the reserved value 3 stays
    // representable; hence plain constants rather than an enum.
    localparam logic [1:0] DTM_NOP     = 2'd0;
    localparam logic [1:0] DTM_READ    = 2'd1;
    localparam logic [1:0] DTM_WRITE   = 2'd2;

    localparam logic [1:0] DTM_SUCCESS = 2'd0;
    localparam logic [1:0] DTM_FAILED  = 2'd2;

endpackage

// File: rtl/dmi_bridge_serv.sv
// ---------------------------------------------------------------------------
// dmi_bridge_serv : core-side DMI bridge.
//
// Purpose
//   Accepts one DMI request at a time from the core side of the request
//   crossing, runs it as a single access on the debug-module register bus,
//   and presents the result to the response crossing. NOP and the reserved
//   op are answered locally without touching the bus. An access that does
//   not complete within TimeoutCycles is abandoned with a FAILED response.
//
// Parameters
//   TimeoutCycles  max cycles from bus-request start to completion (>= 1)
//
// Ports
//   clk_i, rst_i                   core clock, synchronous active-high reset
//   dmi_req_i/_valid_i/_ready_o    request handshake (ready from state only)
//   dmi_resp_o/_valid_o/_ready_i   response handshake (held until ready)
//   reg_req_o                      bus request, high while waiting for grant
//   reg_we_o/addr_o/wdata_o        captured access attributes
//   reg_gnt_i                      request granted
//   reg_rvalid_i/rdata_i/err_i     access completion, read data, error
// ---------------------------------------------------------------------------
module dmi_bridge_serv
    import dm::*;
#(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  dmi_req_t    dmi_req_i,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,

    output dmi_resp_t   dmi_resp_o,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,

    output logic        reg_req_o,
    output logic        reg_we_o,
    output logic [6:0]  reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_gnt_i,
    input  logic        reg_rvalid_i,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_err_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    localparam int unsigned    CntW    = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);
    // The counter reads k-1 during the k-th busy cycle, so the cycle in
    // which the count reaches TimeoutCycles is the one where it reads T-1.
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    dmi_resp_t       r_resp;
    dmi_resp_t       w_resp_nxt;
    logic [6:0]      r_addr;
    logic            r_we;
    logic [31:0]     r_wdata;
    logic [CntW-1:0] r_cnt;

    logic            w_accept;
    logic            w_done;
    logic            w_timeout;
    logic            w_busy;

    // ------------------------------------------------------------------
    // Next-state / response logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_resp_nxt  = r_resp;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (dmi_req_valid_i) begin
                    w_accept = 1'b1;
                    unique case (dmi_req_i.op)
                        DTM_NOP: begin
                            w_resp_nxt  = '{data: 32'h0, resp: DTM_SUCCESS};
                            w_state_nxt = S_RESP;
                        end
                        DTM_READ, DTM_WRITE: begin
                            w_state_nxt = S_ISSUE;
                        end
                        default: begin
                            w_resp_nxt  = '{data: 32'h0, resp: DTM_FAILED};
                            w_state_nxt = S_RESP;
                        end
                    endcase
                end
            end

            S_ISSUE, S_WAIT: begin
                // A completion arriving with the grant counts the same as
                // one arriving later in WAIT.
                w_done    = reg_rvalid_i & ((r_state == S_WAIT) | reg_gnt_i);
                w_timeout = (r_cnt == CntLast);

                if (w_done) begin
                    w_resp_nxt.data = r_we ? 32'h0 : reg_rdata_i;
                    w_resp_nxt.resp = reg_err_i ? DTM_FAILED : DTM_SUCCESS;
                    w_state_nxt     = S_RESP;
                end else if (w_timeout) begin
                    w_resp_nxt  = '{data: 32'h0, resp: DTM_FAILED};
                    w_state_nxt = S_RESP;
                end else if ((r_state == S_ISSUE) && reg_gnt_i) begin
                    w_state_nxt = S_WAIT;
                end
            end

            S_RESP: begin
                // Late gnt/rvalid after a timeout land here and are ignored.
                if (dmi_resp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_busy = (r_state == S_ISSUE) || (r_state == S_WAIT);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_resp  <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_resp  <= w_resp_nxt;
            if (w_accept) begin
                r_addr  <= dmi_req_i.addr;
                r_we    <= (dmi_req_i.op == DTM_WRITE);
                // Reads present zero write data on the bus.
                r_wdata <= (dmi_req_i.op == DTM_WRITE) ? dmi_req_i.data : 32'h0;
                r_cnt   <= '0;
            end else if (w_busy && (r_cnt != CntMax)) begin
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Gated by rst_i so ready reads low for the whole reset pulse, not just
    // until the first edge resets the state register.
    assign dmi_req_ready_o  = (r_state == S_IDLE) && !rst_i;

    assign dmi_resp_valid_o = (r_state == S_RESP);
    assign dmi_resp_o       = r_resp;

    assign reg_req_o        = (r_state == S_ISSUE);
    assign reg_we_o         = r_we;
    assign reg_addr_o       = r_addr;
    assign reg_wdata_o      = r_wdata;

endmodule

// File: tb/tb_dmi_bridge_serv.sv
// ---------------------------------------------------------------------------
// tb_dmi_bridge_serv : directed self-checking bench for dmi_bridge_serv.
//
// Cycle k is the interval after the k-th rising edge following acceptance;
// inputs are driven and outputs sampled 1 time unit after each rising edge.
// The DUT runs with TimeoutCycles = 4 so the timeout path is reachable.
// ---------------------------------------------------------------------------
module tb_dmi_bridge_serv;
    import dm::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    dmi_req_t    dmi_req_i;
    logic        dmi_req_valid_i;
    logic        dmi_req_ready_o;
    dmi_resp_t   dmi_resp_o;
    logic        dmi_resp_valid_o;
    logic        dmi_resp_ready_i;
    logic        reg_req_o;
    logic        reg_we_o;
    logic [6:0]  reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic        reg_gnt_i;
    logic        reg_rvalid_i;
    logic [31:0] reg_rdata_i;
    logic        reg_err_i;

    int n_chk  = 0;
    int n_pass = 0;

    dmi_bridge_serv #(.TimeoutCycles(4)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .dmi_req_i        (dmi_req_i),
        .dmi_req_valid_i  (dmi_req_valid_i),
        .dmi_req_ready_o  (dmi_req_ready_o),
        .dmi_resp_o       (dmi_resp_o),
        .dmi_resp_valid_o (dmi_resp_valid_o),
        .dmi_resp_ready_i (dmi_resp_ready_i),
        .reg_req_o        (reg_req_o),
        .reg_we_o         (reg_we_o),
        .reg_addr_o       (reg_addr_o),
        .reg_wdata_o      (reg_wdata_o),
        .reg_gnt_i        (reg_gnt_i),
        .reg_rvalid_i     (reg_rvalid_i),
        .reg_rdata_i      (reg_rdata_i),
        .reg_err_i        (reg_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
        dmi_req_i       = '{addr: a, op: op, data: d};
        dmi_req_valid_i = 1'b1;
    endtask

    task automatic handshake();
        dmi_resp_ready_i = 1'b1;
        step();
        dmi_resp_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_i            = 1'b1;
        dmi_req_i        = '0;
        dmi_req_valid_i  = 1'b0;
        dmi_resp_ready_i = 1'b0;
        reg_gnt_i        = 1'b0;
        reg_rvalid_i     = 1'b0;
        reg_rdata_i      = '0;
        reg_err_i        = 1'b0;

        // ---- reset state ----
        step();
        step();
        chk("rst_ready",  dmi_req_ready_o,  0);
        chk("rst_rvalid", dmi_resp_valid_o, 0);
        chk("rst_resp",   dmi_resp_o,       0);
        chk("rst_req",    reg_req_o,        0);
        chk("rst_we",     reg_we_o,         0);
        chk("rst_addr",   reg_addr_o,       0);
        chk("rst_wdata",  reg_wdata_o,      0);
        rst_i = 1'b0;
        step();
        chk("post_rst_ready", dmi_req_ready_o, 1);

        // ---- read: gnt c1, rvalid c3 -> resp valid c4 ----
        send(DTM_READ, 7'h05, 32'h1111_1111);
        chk("rd_ready_c0", dmi_req_ready_o, 1);
        step();                                   // c1
        dmi_req_valid_i = 1'b0;
        chk("rd_req_c1",   reg_req_o,   1);
        chk("rd_we_c1",    reg_we_o,    0);
        chk("rd_addr_c1",  reg_addr_o,  7'h05);
        chk("rd_wdata_c1", reg_wdata_o, 0);
        chk("rd_busy_c1",  dmi_req_ready_o, 0);
        reg_gnt_i = 1'b1;
        step();                                   // c2
        reg_gnt_i = 1'b0;
        chk("rd_req_c2",  reg_req_o,        0);
        chk("rd_vld_c2",  dmi_resp_valid_o, 0);
        step();                                   // c3
        reg_rvalid_i = 1'b1;
        reg_rdata_i  = 32'hDEAD_BEEF;
        chk("rd_vld_c3",  dmi_resp_valid_o, 0);
        step();                                   // c4
        reg_rvalid_i = 1'b0;
        reg_rdata_i  = '0;
        chk("rd_vld_c4",  dmi_resp_valid_o, 1);
        chk("rd_resp_c4", dmi_resp_o, {32'hDEAD_BEEF, DTM_SUCCESS});
        handshake();                              // c5
        chk("rd_vld_c5",   dmi_resp_valid_o, 0);
        chk("rd_ready_c5", dmi_req_ready_o,  1);

        // ---- write with error, gnt+rvalid c1 -> resp c2 ----
        send(DTM_WRITE, 7'h10, 32'h1234_5678);
        step();                                   // c1
        dmi_req_valid_i = 1'b0;
        chk("wr_req_c1",   reg_req_o,   1);
        chk("wr_we_c1",    reg_we_o,    1);
        chk("wr_addr_c1",  reg_addr_o,  7'h10);
        chk("wr_wdata_c1", reg_wdata_o, 32'h1234_5678);
        reg_gnt_i    = 1'b1;
        reg_rvalid_i = 1'b1;
        reg_err_i    = 1'b1;
        reg_rdata_i  = 32'hFFFF_FFFF;
        step();                                   // c2
        reg_gnt_i    = 1'b0;
        reg_rvalid_i = 1'b0;
        reg_err_i    = 1'b0;
        reg_rdata_i  = '0;
        chk("wr_vld_c2",  dmi_resp_valid_o, 1);
        chk("wr_resp_c2", dmi_resp_o, {32'h0, DTM_FAILED});
        handshake();
        chk("wr_ready_after", dmi_req_ready_o, 1);

        // ---- NOP then reserved op: answered in c1, no bus access ----
        send(DTM_NOP, 7'h01, 32'h0000_ABCD);
        step();
        dmi_req_valid_i = 1'b0;
        chk("nop_vld",  dmi_resp_valid_o, 1);
        chk("nop_resp", dmi_resp_o, {32'h0, DTM_SUCCESS});
        chk("nop_req",  reg_req_o, 0);
        handshake();
        send(2'd3, 7'h02, 32'h5555_AAAA);
        step();
        dmi_req_valid_i = 1'b0;
        chk("rsv_vld",  dmi_resp_valid_o, 1);
        chk("rsv_resp", dmi_resp_o, {32'h0, DTM_FAILED});
        chk("rsv_req",  reg_req_o, 0);
        handshake();

        // ---- timeout: no grant, req high c1..c4, resp c5, late rvalid c7 ----
        send(DTM_READ, 7'h33, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            dmi_req_valid_i = 1'b0;
            chk($sformatf("to_req_c%0d", k), reg_req_o,        1);
            chk($sformatf("to_vld_c%0d", k), dmi_resp_valid_o, 0);
        end
        step();                                   // c5
        chk("to_req_c5",  reg_req_o,        0);
        chk("to_vld_c5",  dmi_resp_valid_o, 1);
        chk("to_resp_c5", dmi_resp_o, {32'h0, DTM_FAILED});
        step();                                   // c6
        step();                                   // c7
        reg_rvalid_i = 1'b1;
        reg_gnt_i    = 1'b1;
        reg_rdata_i  = 32'hAAAA_5555;
        step();                                   // c8
        reg_rvalid_i = 1'b0;
        reg_gnt_i    = 1'b0;
        reg_rdata_i  = '0;
        chk("to_vld_c8",  dmi_resp_valid_o, 1);
        chk("to_resp_c8", dmi_resp_o, {32'h0, DTM_FAILED});
        handshake();
        chk("to_ready_after", dmi_req_ready_o, 1);

        // ---- response held for 10 cycles with ready low ----
        send(DTM_READ, 7'h44, 32'h0);
        step();                                   // c1
        dmi_req_valid_i = 1'b0;
        reg_gnt_i    = 1'b1;
        reg_rvalid_i = 1'b1;
        reg_rdata_i  = 32'hCAFE_F00D;
        step();                                   // c2
        reg_gnt_i    = 1'b0;
        reg_rvalid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            reg_rdata_i = 32'h0101_0101 * (i + 1);
            chk($sformatf("hold_vld_%0d", i),   dmi_resp_valid_o, 1);
            chk($sformatf("hold_resp_%0d", i),  dmi_resp_o, {32'hCAFE_F00D, DTM_SUCCESS});
            chk($sformatf("hold_ready_%0d", i), dmi_req_ready_o, 0);
            step();
        end
        reg_rdata_i      = '0;
        dmi_resp_ready_i = 1'b1;
        send(DTM_NOP, 7'h00, 32'h0);
        chk("hold_ready_hs", dmi_req_ready_o, 0);
        step();
        dmi_resp_ready_i = 1'b0;
        chk("hold_ready_next", dmi_req_ready_o, 1);
        step();
        dmi_req_valid_i = 1'b0;
        chk("hold_nop_vld",  dmi_resp_valid_o, 1);
        chk("hold_nop_resp", dmi_resp_o, {32'h0, DTM_SUCCESS});
        handshake();

        // ---- reset while in WAIT, then a normal read ----
        send(DTM_READ, 7'h55, 32'h0);
        step();                                   // c1
        dmi_req_valid_i = 1'b0;
        reg_gnt_i = 1'b1;
        step();                                   // c2 (WAIT)
        reg_gnt_i = 1'b0;
        chk("mr_req_wait", reg_req_o, 0);
        rst_i = 1'b1;
        step();
        chk("mr_ready", dmi_req_ready_o,  0);
        chk("mr_vld",   dmi_resp_valid_o, 0);
        chk("mr_resp",  dmi_resp_o,       0);
        chk("mr_req",   reg_req_o,        0);
        chk("mr_addr",  reg_addr_o,       0);
        rst_i = 1'b0;
        step();
        chk("mr_ready_after", dmi_req_ready_o,  1);
        chk("mr_vld_after",   dmi_resp_valid_o, 0);
        send(DTM_READ, 7'h22, 32'h0);
        step();                                   // c1
        dmi_req_valid_i = 1'b0;
        chk("mr_rd_addr", reg_addr_o, 7'h22);
        chk("mr_rd_req",  reg_req_o,  1);
        reg_gnt_i    = 1'b1;
        reg_rvalid_i = 1'b1;
        reg_rdata_i  = 32'h0BAD_CAFE;
        step();                                   // c2
        reg_gnt_i    = 1'b0;
        reg_rvalid_i = 1'b0;
        reg_rdata_i  = '0;
        chk("mr_rd_vld",  dmi_resp_valid_o, 1);
        chk("mr_rd_resp", dmi_resp_o, {32'h0BAD_CAFE, DTM_SUCCESS});
        handshake();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
